ro_puf_meas_ctrl: RTL and testbench

Sequences one PUF challenge-response measurement over the 16-entry ring-oscillator array. Each challenge byte selects two oscillators, A and B. The block drives the 4-bit select into the one-hot RO-enable decoder and gates/clears the shared edge counter. It measures A, then B, over a fixed window and returns one response bit from the count comparison. It sits between the challenge source (UART/host FSM) and the RO array + counter.

---
 rtl/ro_puf_pkg.sv | 23 ++
 rtl/ro_window_timer.sv | 33 +++
 rtl/ro_puf_meas_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ro_puf_meas_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement controller.
// Holds the RO array geometry, challenge width and the measurement state type.
package ro_puf_pkg;

    localparam int NUM_RO = 16;
    localparam int SEL_W  = $clog2(NUM_RO);
    localparam int CHAL_W = 2 * SEL_W;

    // One measurement walks A then B through clear, window, settle and capture.
    typedef enum logic [3:0] {
        IDLE,
        CLR_A,
        MEAS_A,
        SETTLE_A,
        CAP_A,
        CLR_B,
        MEAS_B,
        SETTLE_B,
        CAP_B,
        DONE
    } meas_state_t;

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter used to time the measurement window and the settle gap.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_load     load i_load_val this cycle (wins over counting)
//   i_load_val value to load
//   o_zero     counter currently at zero
module ro_window_timer #(
    parameter int TW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    // Counts down once per cycle and parks at zero until reloaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ro_puf_meas_ctrl.sv
// Sequences one challenge-response measurement over the ring-oscillator array:
// measure RO A, then RO B, over a fixed window and report whether A counted more.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_challenge  request + challenge ([7:4]=A, [3:0]=B), sampled in IDLE
//   i_abort               cancel an in-flight measurement
//   i_cnt_val             external RO edge counter value
//   o_ro_sel, o_ro_en     oscillator index and enable gate for the decoder
//   o_cnt_clr             synchronous clear for the edge counter
//   o_busy                high outside IDLE
//   o_resp_valid          one-cycle pulse, response fields valid
//   o_resp_bit/tie/err    A>B, A==B counts, challenge had A==B
//   o_count_a/b           captured counts, held until next capture
module ro_puf_meas_ctrl
    import ro_puf_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CHAL_W-1:0] i_challenge,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_cnt_val,
    output logic [SEL_W-1:0]  o_ro_sel,
    output logic              o_ro_en,
    output logic              o_cnt_clr,
    output logic              o_busy,
    output logic              o_resp_valid,
    output logic              o_resp_bit,
    output logic              o_resp_tie,
    output logic              o_resp_err,
    output logic [CNT_W-1:0]  o_count_a,
    output logic [CNT_W-1:0]  o_count_b
);

    localparam int MAX_T = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW - 1);
    localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE - 1);

    meas_state_t      r_state;
    meas_state_t      w_next;
    logic             w_load;
    logic [TW-1:0]    w_load_val;
    logic             w_zero;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] r_ro_sel;
    logic             r_ro_en;
    logic             r_cnt_clr;
    logic             r_busy;
    logic             r_resp_valid;
    logic             r_resp_bit;
    logic             r_resp_tie;
    logic             r_resp_err;
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;

    ro_window_timer #(.TW(TW)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // A is still being latched on the cycle CLR_A is entered, so take it live.
    assign w_sel_a = (r_state == IDLE) ? i_challenge[2*SEL_W-1:SEL_W] : r_sel_a;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The timer is reloaded on entry to every MEAS/SETTLE phase; a phase ends
    // on the cycle the timer reads zero. Abort overrides every transition.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (i_challenge[2*SEL_W-1:SEL_W] == i_challenge[SEL_W-1:0])
                             ? DONE : CLR_A;
                end
            end
            CLR_A: begin
                w_next     = MEAS_A;
                w_load     = 1'b1;
                w_load_val = WIN_LOAD;
            end
            MEAS_A: begin
                if (w_zero) begin
                    w_next     = SETTLE_A;
                    w_load     = 1'b1;
                    w_load_val = SET_LOAD;
                end
            end
            SETTLE_A: if (w_zero) w_next = CAP_A;
            CAP_A:    w_next = CLR_B;
            CLR_B: begin
                w_next     = MEAS_B;
                w_load     = 1'b1;
                w_load_val = WIN_LOAD;
            end
            MEAS_B: begin
                if (w_zero) begin
                    w_next     = SETTLE_B;
                    w_load     = 1'b1;
                    w_load_val = SET_LOAD;
                end
            end
            SETTLE_B: if (w_zero) w_next = CAP_B;
            CAP_B:    w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
        if (i_abort && (r_state != IDLE) && (r_state != DONE)) begin
            w_next = IDLE;
            w_load = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe. Captures and responses only happen on the
    // non-aborted path, so an abort leaves count_* and resp_* untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_a      <= '0;
            r_sel_b      <= '0;
            r_ro_sel     <= '0;
            r_ro_en      <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_bit   <= 1'b0;
            r_resp_tie   <= 1'b0;
            r_resp_err   <= 1'b0;
            r_count_a    <= '0;
            r_count_b    <= '0;
        end else begin
            if ((r_state == IDLE) && i_start) begin
                r_sel_a <= i_challenge[2*SEL_W-1:SEL_W];
                r_sel_b <= i_challenge[SEL_W-1:0];
            end
            r_busy       <= (w_next != IDLE);
            r_ro_en      <= (w_next == MEAS_A) || (w_next == MEAS_B);
            r_cnt_clr    <= (w_next == CLR_A) || (w_next == CLR_B);
            r_resp_valid <= (w_next == DONE);
            case (w_next)
                CLR_A, MEAS_A, SETTLE_A, CAP_A: r_ro_sel <= w_sel_a;
                CLR_B, MEAS_B, SETTLE_B, CAP_B: r_ro_sel <= r_sel_b;
                default:                        r_ro_sel <= '0;
            endcase
            if ((r_state == CAP_A) && (w_next == CLR_B)) begin
                r_count_a <= i_cnt_val;
            end
            if (w_next == DONE) begin
                if (r_state == CAP_B) begin
                    r_count_b  <= i_cnt_val;
                    r_resp_bit <= (r_count_a > i_cnt_val);
                    r_resp_tie <= (r_count_a == i_cnt_val);
                    r_resp_err <= 1'b0;
                end else begin
                    r_resp_bit <= 1'b0;
                    r_resp_tie <= 1'b0;
                    r_resp_err <= 1'b1;
                end
            end
        end
    end

    assign o_ro_sel     = r_ro_sel;
    assign o_ro_en      = r_ro_en;
    assign o_cnt_clr    = r_cnt_clr;
    assign o_busy       = r_busy;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_bit   = r_resp_bit;
    assign o_resp_tie   = r_resp_tie;
    assign o_resp_err   = r_resp_err;
    assign o_count_a    = r_count_a;
    assign o_count_b    = r_count_b;

endmodule

// File: tb/tb_ro_puf_meas_ctrl.sv
// Bench for ro_puf_meas_ctrl with WINDOW=8, SETTLE=2. An RO edge counter
// model produces a fixed total per oscillator over one window; a timeline
// model of the measurement predicts every output on every cycle.
module tb_ro_puf_meas_ctrl;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int LAT  = 2 * W + 2 * S + 5;
    localparam int CAPA = W + S + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  challenge;
    logic        abort;
    logic [15:0] cntVal = '0;
    logic [3:0]  roSel;
    logic        roEn;
    logic        cntClr;
    logic        busy;
    logic        respValid;
    logic        respBit;
    logic        respTie;
    logic        respErr;
    logic [15:0] countA;
    logic [15:0] countB;

    int roTotal [16];
    int cntK = 0;
    int cyc = 0;
    int startCyc = 0;
    int scen = 0;
    bit checkEn = 1'b0;
    int testsRun = 0;
    int failCount = 0;

    int litLat [8];
    int litCa  [8];
    int litCb  [8];
    int litBit [8];
    int litTie [8];
    int litErr [8];

    int         mN = 0;
    int         mLen = 0;
    logic [3:0] mA = '0;
    logic [3:0] mB = '0;
    logic [15:0] expCountA = '0;
    logic [15:0] expCountB = '0;
    logic       expBit = 1'b0;
    logic       expTie = 1'b0;
    logic       expErr = 1'b0;

    logic [3:0] eSel;
    logic       eEn;
    logic       eClr;
    logic       eBusy;
    logic       eValid;

    ro_puf_meas_ctrl #(.WINDOW(W), .SETTLE(S), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_challenge  (challenge),
        .i_abort      (abort),
        .i_cnt_val    (cntVal),
        .o_ro_sel     (roSel),
        .o_ro_en      (roEn),
        .o_cnt_clr    (cntClr),
        .o_busy       (busy),
        .o_resp_valid (respValid),
        .o_resp_bit   (respBit),
        .o_resp_tie   (respTie),
        .o_resp_err   (respErr),
        .o_count_a    (countA),
        .o_count_b    (countB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External edge counter: ramps to roTotal[sel] after W enabled cycles.
    always @(posedge clk) begin
        if (cntClr) begin
            cntVal <= '0;
            cntK   <= 0;
        end else if (roEn) begin
            cntK   <= cntK + 1;
            cntVal <= 16'((roTotal[roSel] * (cntK + 1)) / W);
        end
    end

    // Timeline model: mN is the cycle number within the current measurement
    // (0 when idle), mLen the cycle on which the response appears.
    always @(posedge clk) begin
        if (rst) begin
            mN        <= 0;
            mLen      <= 0;
            expCountA <= '0;
            expCountB <= '0;
            expBit    <= 1'b0;
            expTie    <= 1'b0;
            expErr    <= 1'b0;
        end else if (mN == 0) begin
            if (start) begin
                mA <= challenge[7:4];
                mB <= challenge[3:0];
                mN <= 1;
                if (challenge[7:4] == challenge[3:0]) begin
                    mLen   <= 1;
                    expErr <= 1'b1;
                    expBit <= 1'b0;
                    expTie <= 1'b0;
                end else begin
                    mLen <= LAT;
                end
            end
        end else if (abort && mN != mLen) begin
            mN <= 0;
        end else if (mN == mLen) begin
            mN <= 0;
        end else begin
            mN <= mN + 1;
            if (mN + 1 == CAPA) expCountA <= 16'(roTotal[mA]);
            if (mN + 1 == mLen) begin
                expCountB <= 16'(roTotal[mB]);
                expBit    <= roTotal[mA] > roTotal[mB];
                expTie    <= roTotal[mA] == roTotal[mB];
                expErr    <= 1'b0;
            end
        end
    end

    assign eBusy  = (mN != 0);
    assign eValid = (mN != 0) && (mN == mLen);
    assign eSel   = (mN == 0 || mLen == 1) ? 4'd0 :
                    (mN <= W + S + 2) ? mA :
                    (mN <= 2 * W + 2 * S + 4) ? mB : 4'd0;
    assign eEn    = (mN != 0) && (mLen != 1) &&
                    ((mN >= 2 && mN <= W + 1) || (mN >= W + S + 4 && mN <= 2 * W + S + 3));
    assign eClr   = (mN != 0) && (mLen != 1) && (mN == 1 || mN == W + S + 3);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (act !== exp) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle against the model, plus the literal
    // response table whenever the DUT raises resp_valid.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("ro_sel", 32'(roSel), 32'(eSel));
            checkOutput("ro_en", 32'(roEn), 32'(eEn));
            checkOutput("cnt_clr", 32'(cntClr), 32'(eClr));
            checkOutput("busy", 32'(busy), 32'(eBusy));
            checkOutput("resp_valid", 32'(respValid), 32'(eValid));
            checkOutput("resp_bit", 32'(respBit), 32'(expBit));
            checkOutput("resp_tie", 32'(respTie), 32'(expTie));
            checkOutput("resp_err", 32'(respErr), 32'(expErr));
            checkOutput("count_a", 32'(countA), 32'(expCountA));
            checkOutput("count_b", 32'(countB), 32'(expCountB));
            if (respValid) begin
                checkOutput("lit_latency", 32'(cyc - startCyc), 32'(litLat[scen]));
                checkOutput("lit_count_a", 32'(countA), 32'(litCa[scen]));
                checkOutput("lit_count_b", 32'(countB), 32'(litCb[scen]));
                checkOutput("lit_resp_bit", 32'(respBit), 32'(litBit[scen]));
                checkOutput("lit_resp_tie", 32'(respTie), 32'(litTie[scen]));
                checkOutput("lit_resp_err", 32'(respErr), 32'(litErr[scen]));
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] chal, input int id);
        scen      = id;
        startCyc  = cyc;
        challenge = chal;
        start     = 1'b1;
        stepCycles(1);
        start     = 1'b0;
    endtask

    task automatic setLit(input int id, input int lat, input int ca, input int cb,
                          input int b, input int t, input int e);
        litLat[id] = lat;
        litCa[id]  = ca;
        litCb[id]  = cb;
        litBit[id] = b;
        litTie[id] = t;
        litErr[id] = e;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) roTotal[i] = 20 + 7 * i;
        roTotal[3]  = 100;
        roTotal[10] = 80;
        roTotal[1]  = 50;
        roTotal[2]  = 50;
        for (int i = 0; i < 8; i++) setLit(i, -1, 0, 0, 0, 0, 0);
        setLit(1, 25, 100, 80, 1, 0, 0);
        setLit(2, 25, 50, 50, 0, 1, 0);
        setLit(3, 1, 50, 50, 0, 0, 1);
        setLit(4, 42, 48, 104, 0, 0, 0);
        setLit(5, 25, 80, 100, 0, 0, 0);
        setLit(7, 25, 100, 80, 1, 0, 0);

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        challenge = 8'h00;
        stepCycles(3);
        checkEn = 1'b1;
        rst     = 1'b0;
        stepCycles(5);

        applyStimulus(8'h3A, 1);
        stepCycles(27);

        applyStimulus(8'h21, 2);
        stepCycles(24);
        abort = 1'b1;
        stepCycles(1);
        abort = 1'b0;
        stepCycles(3);

        applyStimulus(8'h55, 3);
        stepCycles(4);

        applyStimulus(8'h3A, 4);
        stepCycles(14);
        abort = 1'b1;
        stepCycles(1);
        abort = 1'b0;
        stepCycles(1);
        challenge = 8'h4C;
        start     = 1'b1;
        stepCycles(1);
        start     = 1'b0;
        stepCycles(27);

        applyStimulus(8'hA3, 5);
        stepCycles(4);
        challenge = 8'h77;
        start     = 1'b1;
        stepCycles(1);
        start     = 1'b0;
        stepCycles(4);
        challenge = 8'h12;
        start     = 1'b1;
        stepCycles(1);
        start     = 1'b0;
        stepCycles(14);
        start     = 1'b1;
        stepCycles(1);
        start     = 1'b0;
        stepCycles(4);

        applyStimulus(8'h3A, 6);
        stepCycles(4);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        stepCycles(2);
        applyStimulus(8'h3A, 7);
        stepCycles(27);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
